// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame sequencer: default widths and FSM state encoding.
package conv_pkg;

    localparam int unsigned NbPixelDef = 8;
    localparam int unsigned NbAddrDef  = 10;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StRun   = 3'd2;
    localparam state_t StDrain = 3'd3;
    localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/conv_valid_delay.sv
// Lat-deep 1-bit shift register; aligns the read strobe with the convolver's result.
module conv_valid_delay #(
    parameter int unsigned Lat = 3
) (
    input  logic i_CLK,
    input  logic i_rst,
    input  logic d_i,
    output logic q_o
);

    logic [Lat-1:0] sr_q;
    logic [Lat-1:0] sr_d;

    generate
        if (Lat == 1) begin : g_single
            always_comb sr_d = d_i;
        end else begin : g_chain
            always_comb sr_d = {sr_q[Lat-2:0], d_i};
        end
    endgenerate

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[Lat-1];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer: loads GPIO pixels column-wise into the frame buffer, then sweeps 3-column
// windows through the convolver and streams result-memory writes, flagging EOP at the end.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned NB_PIXEL = NbPixelDef,
    parameter int unsigned NB_ADDR  = NbAddrDef,
    parameter int unsigned N_COLS   = 8,
    parameter int unsigned NB_COL   = 3,
    parameter int unsigned CONV_LAT = 3
) (
    input  logic                      i_CLK,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic                      i_run,
    input  logic                      i_valid,
    input  logic [NB_PIXEL-1:0]       i_data,
    input  logic [NB_ADDR-1:0]        i_imgLength,
    output logic                      o_wr_en,
    output logic [NB_COL-1:0]         o_wr_col,
    output logic [NB_ADDR-1:0]        o_wr_addr,
    output logic [NB_PIXEL-1:0]       o_wr_data,
    output logic                      o_rd_en,
    output logic [NB_COL-1:0]         o_rd_col,
    output logic [NB_ADDR-1:0]        o_rd_addr,
    output logic                      o_res_we,
    output logic [NB_ADDR+NB_COL-1:0] o_res_addr,
    output logic                      o_EOP,
    output logic                      o_err
);

    localparam int unsigned ColsW   = NB_COL + 1;
    localparam int unsigned NbDrain = $clog2(CONV_LAT + 1);

    localparam logic [ColsW-1:0]   ColsMax  = ColsW'(N_COLS);
    localparam logic [ColsW-1:0]   ColsMin  = ColsW'(3);
    localparam logic [NB_ADDR-1:0] LenMin   = NB_ADDR'(3);
    localparam logic [NbDrain-1:0] DrainEnd = NbDrain'(CONV_LAT - 1);

    state_t                      state_q, state_d;
    logic [NB_ADDR-1:0]          len_q, len_d;
    logic [ColsW-1:0]            cols_q, cols_d;
    logic [NB_ADDR-1:0]          wr_addr_q, wr_addr_d;
    logic [NB_ADDR-1:0]          rd_addr_q, rd_addr_d;
    logic [NB_COL-1:0]           rd_col_q, rd_col_d;
    logic [NbDrain-1:0]          drain_q, drain_d;
    logic [NB_ADDR+NB_COL-1:0]   res_addr_q, res_addr_d;
    logic                        eop_q, eop_d;
    logic                        err_q, err_d;
    logic                        wr_en_q, wr_en_d;
    logic [NB_COL-1:0]           wr_col_out_q, wr_col_out_d;
    logic [NB_ADDR-1:0]          wr_addr_out_q, wr_addr_out_d;
    logic [NB_PIXEL-1:0]         wr_data_q, wr_data_d;
    logic                        rd_en;
    logic                        res_we;

    assign rd_en = (state_q == StRun);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cols_d        = cols_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        rd_col_d      = rd_col_q;
        drain_d       = drain_q;
        res_addr_d    = res_we ? res_addr_q + 1'b1 : res_addr_q;
        eop_d         = eop_q;
        err_d         = err_q;
        wr_en_d       = 1'b0;
        wr_col_out_d  = wr_col_out_q;
        wr_addr_out_d = wr_addr_out_q;
        wr_data_d     = wr_data_q;

        case (state_q)
            StIdle, StDone: begin
                if (i_load) begin
                    state_d   = StLoad;
                    len_d     = i_imgLength;
                    cols_d    = '0;
                    wr_addr_d = '0;
                    eop_d     = 1'b0;
                    err_d     = 1'b0;
                end
            end
            StLoad: begin
                if (i_valid) begin
                    if (cols_q == ColsMax) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d       = 1'b1;
                        wr_col_out_d  = cols_q[NB_COL-1:0];
                        wr_addr_out_d = wr_addr_q;
                        wr_data_d     = i_data;
                        if (wr_addr_q == len_q - 1'b1) begin
                            wr_addr_d = '0;
                            cols_d    = cols_q + 1'b1;
                        end else begin
                            wr_addr_d = wr_addr_q + 1'b1;
                        end
                    end
                end
                // Decision sees a column completed by a same-cycle pixel.
                if (i_run) begin
                    if (cols_d >= ColsMin && len_q >= LenMin) begin
                        state_d    = StRun;
                        rd_addr_d  = '0;
                        rd_col_d   = '0;
                        res_addr_d = '0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        eop_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                if (rd_addr_q == len_q - 1'b1) begin
                    if ({1'b0, rd_col_q} == cols_q - ColsMin) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        rd_addr_d = '0;
                        rd_col_d  = rd_col_q + 1'b1;
                    end
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainEnd) begin
                    state_d = StDone;
                    eop_d   = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state_q       <= StIdle;
            len_q         <= '0;
            cols_q        <= '0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_col_q      <= '0;
            drain_q       <= '0;
            res_addr_q    <= '0;
            eop_q         <= 1'b0;
            err_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_col_out_q  <= '0;
            wr_addr_out_q <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cols_q        <= cols_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_col_q      <= rd_col_d;
            drain_q       <= drain_d;
            res_addr_q    <= res_addr_d;
            eop_q         <= eop_d;
            err_q         <= err_d;
            wr_en_q       <= wr_en_d;
            wr_col_out_q  <= wr_col_out_d;
            wr_addr_out_q <= wr_addr_out_d;
            wr_data_q     <= wr_data_d;
        end
    end

    conv_valid_delay #(
        .Lat (CONV_LAT)
    ) u_res_delay (
        .i_CLK (i_CLK),
        .i_rst (i_rst),
        .d_i   (rd_en),
        .q_o   (res_we)
    );

    assign o_wr_en    = wr_en_q;
    assign o_wr_col   = wr_col_out_q;
    assign o_wr_addr  = wr_addr_out_q;
    assign o_wr_data  = wr_data_q;
    assign o_rd_en    = rd_en;
    assign o_rd_col   = rd_col_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_res_we   = res_we;
    assign o_res_addr = res_addr_q;
    assign o_EOP      = eop_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with queue-based scoreboards for buffer writes,
// window reads and result writes.
module tb_conv_frame_sequencer;

    localparam int NB_PIXEL = 8;
    localparam int NB_ADDR  = 10;
    localparam int N_COLS   = 8;
    localparam int NB_COL   = 3;
    localparam int CONV_LAT = 3;

    logic                      i_CLK = 1'b0;
    logic                      i_rst = 1'b1;
    logic                      i_load = 1'b0;
    logic                      i_run = 1'b0;
    logic                      i_valid = 1'b0;
    logic [NB_PIXEL-1:0]       i_data = '0;
    logic [NB_ADDR-1:0]        i_imgLength = '0;
    logic                      o_wr_en;
    logic [NB_COL-1:0]         o_wr_col;
    logic [NB_ADDR-1:0]        o_wr_addr;
    logic [NB_PIXEL-1:0]       o_wr_data;
    logic                      o_rd_en;
    logic [NB_COL-1:0]         o_rd_col;
    logic [NB_ADDR-1:0]        o_rd_addr;
    logic                      o_res_we;
    logic [NB_ADDR+NB_COL-1:0] o_res_addr;
    logic                      o_EOP;
    logic                      o_err;

    conv_frame_sequencer #(
        .NB_PIXEL (NB_PIXEL),
        .NB_ADDR  (NB_ADDR),
        .N_COLS   (N_COLS),
        .NB_COL   (NB_COL),
        .CONV_LAT (CONV_LAT)
    ) dut (
        .i_CLK       (i_CLK),
        .i_rst       (i_rst),
        .i_load      (i_load),
        .i_run       (i_run),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_imgLength (i_imgLength),
        .o_wr_en     (o_wr_en),
        .o_wr_col    (o_wr_col),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_rd_en     (o_rd_en),
        .o_rd_col    (o_rd_col),
        .o_rd_addr   (o_rd_addr),
        .o_res_we    (o_res_we),
        .o_res_addr  (o_res_addr),
        .o_EOP       (o_EOP),
        .o_err       (o_err)
    );

    always #5 i_CLK = ~i_CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rd_cyc = 0;

    logic [NB_COL+NB_ADDR+NB_PIXEL-1:0] exp_wr[$];
    logic [NB_COL+NB_ADDR-1:0]          exp_rd[$];
    logic [NB_ADDR+NB_COL-1:0]          exp_res[$];

    int m_len, m_addr, m_cols;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge i_CLK) cyc++;

    always @(negedge i_CLK) begin
        if (o_wr_en) begin
            check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) check("wr_beat", {o_wr_col, o_wr_addr, o_wr_data},
                                          exp_wr.pop_front());
        end
        if (o_rd_en) begin
            last_rd_cyc = cyc;
            check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
            if (exp_rd.size() != 0) check("rd_beat", {o_rd_col, o_rd_addr}, exp_rd.pop_front());
        end
        if (o_res_we) begin
            check("res_expected", 64'(exp_res.size() != 0), 64'd1);
            if (exp_res.size() != 0) check("res_addr", o_res_addr, exp_res.pop_front());
        end
    end

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic start_load(input int len);
        i_imgLength = NB_ADDR'(len);
        i_load = 1'b1;
        m_len = len;
        m_addr = 0;
        m_cols = 0;
        tick();
        i_load = 1'b0;
    endtask

    task automatic pixel_model(input logic [NB_PIXEL-1:0] d);
        if (m_cols < N_COLS) begin
            exp_wr.push_back({NB_COL'(m_cols), NB_ADDR'(m_addr), d});
            if (m_addr == m_len - 1) begin
                m_addr = 0;
                m_cols++;
            end else begin
                m_addr++;
            end
        end
    endtask

    task automatic pixel(input logic [NB_PIXEL-1:0] d);
        pixel_model(d);
        i_valid = 1'b1;
        i_data = d;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic run_model();
        int n;
        n = 0;
        if (m_cols >= 3 && m_len >= 3) begin
            for (int c = 0; c <= m_cols - 3; c++) begin
                for (int r = 0; r < m_len; r++) begin
                    exp_rd.push_back({NB_COL'(c), NB_ADDR'(r)});
                    exp_res.push_back((NB_ADDR + NB_COL)'(n));
                    n++;
                end
            end
        end
    endtask

    task automatic do_run();
        run_model();
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
    endtask

    task automatic wait_eop(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge i_CLK);
            if (o_EOP) break;
        end
        check(tag, 64'(o_EOP), 64'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        check({tag, "_rd_left"}, 64'(exp_rd.size()), 64'd0);
        check({tag, "_res_left"}, 64'(exp_res.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"}, {o_wr_en, o_wr_col, o_wr_addr, o_wr_data}, 64'd0);
        check({tag, "_rd"}, {o_rd_en, o_rd_col, o_rd_addr, o_res_we, o_res_addr, o_EOP, o_err},
              64'd0);
    endtask

    initial begin
        tick();
        tick();
        check_all_zero("reset");
        i_rst = 1'b0;

        // 1: len 4, three columns -> one window pass
        start_load(4);
        for (int i = 1; i <= 12; i++) pixel(NB_PIXEL'(i));
        do_run();
        wait_eop("t1_eop");
        check("t1_err", 64'(o_err), 64'd0);
        check_drained("t1");

        // 2: five columns -> three passes; EOP latency after last read
        start_load(4);
        for (int i = 0; i < 20; i++) pixel(NB_PIXEL'(100 + i));
        do_run();
        wait_eop("t2_eop");
        check("t2_eop_latency", 64'(cyc - last_rd_cyc), 64'(CONV_LAT + 1));
        check_drained("t2");

        // 3: too few columns
        start_load(4);
        for (int i = 0; i < 8; i++) pixel(NB_PIXEL'(50 + i));
        do_run();
        check("t3_err", 64'(o_err), 64'd1);
        check("t3_eop", 64'(o_EOP), 64'd1);
        check_drained("t3");

        // 4: overflow past N_COLS drops the write but a run still proceeds
        start_load(3);
        check("t4_err_cleared", 64'(o_err), 64'd0);
        for (int i = 0; i < 24; i++) pixel(NB_PIXEL'(i * 3));
        pixel(8'hAA);
        check("t4_wr_drop", 64'(o_wr_en), 64'd0);
        check("t4_err", 64'(o_err), 64'd1);
        do_run();
        wait_eop("t4_eop");
        check_drained("t4");

        // 5: reset in the middle of RUN
        start_load(4);
        for (int i = 0; i < 16; i++) pixel(NB_PIXEL'(200 + i));
        do_run();
        repeat (5) tick();
        i_rst = 1'b1;
        tick();
        exp_wr.delete();
        exp_rd.delete();
        exp_res.delete();
        check_all_zero("t5_abort");
        i_rst = 1'b0;
        tick();
        check_all_zero("t5_idle");
        start_load(4);
        for (int i = 0; i < 12; i++) pixel(NB_PIXEL'(30 + i));
        do_run();
        wait_eop("t5_eop");
        check("t5_err", 64'(o_err), 64'd0);
        check_drained("t5");

        // 6: DONE -> LOAD, last pixel arrives with the run request
        start_load(4);
        check("t6_eop_drop", 64'(o_EOP), 64'd0);
        for (int i = 0; i < 11; i++) pixel(NB_PIXEL'(70 + i));
        pixel_model(8'h99);
        run_model();
        i_valid = 1'b1;
        i_data = 8'h99;
        i_run = 1'b1;
        tick();
        i_valid = 1'b0;
        i_run = 1'b0;
        wait_eop("t6_eop");
        check("t6_err", 64'(o_err), 64'd0);
        check_drained("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
